// File: rtl/attention_top.sv
// Pipelined Q8.8 attention core, softmax(Q*K^T)*V over TOKEN_NUM tokens; 3-cycle latency.
// Accepts one block every clock with no backpressure; define ATTN_SCALE_EN to shift scores by SCALE_SHIFT.
module attention_top #(
  parameter int DATA_WIDTH  = 16,
  parameter int TOKEN_DIM   = 4,
  parameter int TOKEN_NUM   = 8,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] token_out
);

  localparam int DW     = DATA_WIDTH;
  localparam int TD     = TOKEN_DIM;
  localparam int TN     = TOKEN_NUM;
  localparam int MAT_W  = DW * TD * TN;
  localparam int SCR_W  = DW * TN * TN;
  localparam int PROD_W = 2 * DW;
  localparam int ACC_W  = 40;
  localparam int SUM_W  = 9 + $clog2(TN);

`ifdef ATTN_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif
  localparam int A_SHIFT = 8 + (SCALE_EN ? SCALE_SHIFT : 0);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return {1'b0, {(DW-1){1'b1}}};
    if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    return v[DW-1:0];
  endfunction

  logic [SCR_W-1:0] A_stage_1_to_2, a_next;
  logic [SCR_W-1:0] S_stage_2_to_3, s_next;
  logic [MAT_W-1:0] v_stage_1_to_2, v_stage_2_to_3, out_next;

  // Stage 1: dot products, rescale from Q16.16 to Q8.8, saturate
  logic signed [DW-1:0]    q_el, k_el;
  logic signed [ACC_W-1:0] dot;

  always_comb begin
    a_next = '0;
    q_el   = '0;
    k_el   = '0;
    dot    = '0;
    for (int i = 0; i < TN; i++) begin
      for (int j = 0; j < TN; j++) begin
        dot = '0;
        for (int d = 0; d < TD; d++) begin
          q_el = Q[DW*(i*TD+d) +: DW];
          k_el = K[DW*(j*TD+d) +: DW];
          dot  = dot + ACC_W'(PROD_W'(q_el) * PROD_W'(k_el));
        end
        a_next[DW*(i*TN+j) +: DW] = sat(dot >>> A_SHIFT);
      end
    end
  end

  // Stage 2: base-2 softmax; the row max always contributes 256 so the divisor is never zero
  logic signed [DW-1:0] row_max, a_el;
  logic [DW:0]          neg_x;
  logic [DW+1:0]        y;
  logic [8:0]           e_val [TN];
  logic [SUM_W-1:0]     e_sum;
  logic [16:0]          quot;

  always_comb begin
    s_next  = '0;
    row_max = '0;
    a_el    = '0;
    neg_x   = '0;
    y       = '0;
    e_sum   = '0;
    quot    = '0;
    for (int j = 0; j < TN; j++) e_val[j] = '0;
    for (int i = 0; i < TN; i++) begin
      row_max = A_stage_1_to_2[DW*(i*TN) +: DW];
      for (int j = 1; j < TN; j++) begin
        a_el = A_stage_1_to_2[DW*(i*TN+j) +: DW];
        if (a_el > row_max) row_max = a_el;
      end
      e_sum = '0;
      for (int j = 0; j < TN; j++) begin
        a_el  = A_stage_1_to_2[DW*(i*TN+j) +: DW];
        neg_x = (DW+1)'(row_max) - (DW+1)'(a_el);
        y     = (DW+2)'(neg_x) + (DW+2)'(neg_x >> 1) - (DW+2)'(neg_x >> 4);
        if (y[DW+1:12] != '0) e_val[j] = '0;
        else                  e_val[j] = (9'd256 - {2'b00, y[7:1]}) >> y[11:8];
        e_sum = e_sum + SUM_W'(e_val[j]);
      end
      for (int j = 0; j < TN; j++) begin
        quot = {e_val[j], 8'h00} / 17'(e_sum);
        s_next[DW*(i*TN+j) +: DW] = DW'(quot);
      end
    end
  end

  // Stage 3: probability-weighted sum of V rows
  logic [DW-1:0]           s_el;
  logic signed [DW-1:0]    v_el;
  logic signed [ACC_W-1:0] wsum;

  always_comb begin
    out_next = '0;
    s_el     = '0;
    v_el     = '0;
    wsum     = '0;
    for (int i = 0; i < TN; i++) begin
      for (int d = 0; d < TD; d++) begin
        wsum = '0;
        for (int j = 0; j < TN; j++) begin
          s_el = S_stage_2_to_3[DW*(i*TN+j) +: DW];
          v_el = v_stage_2_to_3[DW*(j*TD+d) +: DW];
          wsum = wsum + ACC_W'($signed({1'b0, s_el})) * ACC_W'(v_el);
        end
        out_next[DW*(i*TD+d) +: DW] = sat(wsum >>> 8);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_stage_1_to_2 <= '0;
      v_stage_1_to_2 <= '0;
      S_stage_2_to_3 <= '0;
      v_stage_2_to_3 <= '0;
      token_out      <= '0;
    end else begin
      A_stage_1_to_2 <= a_next;
      v_stage_1_to_2 <= V;
      S_stage_2_to_3 <= s_next;
      v_stage_2_to_3 <= v_stage_1_to_2;
      token_out      <= out_next;
    end
  end

endmodule

// File: tb/tb_attention_top.sv
// Bench for attention_top: directed scenarios plus random back-to-back blocks against an arithmetic model.
module tb_attention_top;

  localparam int DW = 16;
  localparam int TD = 4;
  localparam int TN = 8;
  localparam int MW = DW * TD * TN;
`ifdef ATTN_SCALE_EN
  localparam int SHIFT = 9;
`else
  localparam int SHIFT = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [MW-1:0] q, k, v, token_out;

  int checks = 0;
  int passed = 0;

  attention_top #(
    .DATA_WIDTH (DW),
    .TOKEN_DIM  (TD),
    .TOKEN_NUM  (TN),
    .SCALE_SHIFT(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Q        (q),
    .K        (k),
    .V        (v),
    .token_out(token_out)
  );

  always #5 clk = ~clk;

  function automatic int get_el(input logic [MW-1:0] m, input int r, input int c);
    logic [DW-1:0] b;
    b = m[DW*(r*TD+c) +: DW];
    return int'($signed(b));
  endfunction

  function automatic logic [MW-1:0] set_el(input logic [MW-1:0] m, input int r, input int c, input int val);
    logic [MW-1:0] t;
    t = m;
    t[DW*(r*TD+c) +: DW] = val[DW-1:0];
    return t;
  endfunction

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [MW-1:0] model(input logic [MW-1:0] mq, input logic [MW-1:0] mk, input logic [MW-1:0] mv);
    longint a [TN][TN];
    longint s [TN][TN];
    longint e [TN];
    longint acc, mx, nx, y, n, f, sum;
    logic [MW-1:0] res;
    res = '0;
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) begin
        acc = 0;
        for (int d = 0; d < TD; d++) acc += longint'(get_el(mq, i, d)) * longint'(get_el(mk, j, d));
        a[i][j] = sat16(acc >>> SHIFT);
      end
    for (int i = 0; i < TN; i++) begin
      mx = a[i][0];
      for (int j = 1; j < TN; j++) if (a[i][j] > mx) mx = a[i][j];
      sum = 0;
      for (int j = 0; j < TN; j++) begin
        nx = mx - a[i][j];
        y  = nx + nx / 2 - nx / 16;
        n  = y / 256;
        f  = y % 256;
        e[j] = (n >= 16) ? 0 : ((256 - f / 2) >> n);
        sum += e[j];
      end
      for (int j = 0; j < TN; j++) s[i][j] = (e[j] * 256) / sum;
    end
    for (int i = 0; i < TN; i++)
      for (int d = 0; d < TD; d++) begin
        acc = 0;
        for (int j = 0; j < TN; j++) acc += s[i][j] * longint'(get_el(mv, j, d));
        res = set_el(res, i, d, int'(sat16(acc >>> 8)));
      end
    return res;
  endfunction

  function automatic logic [MW-1:0] rand_small();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < TN; r++)
      for (int c = 0; c < TD; c++) m = set_el(m, r, c, int'($urandom_range(0, 2047)) - 1024);
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_full();
    logic [MW-1:0] m;
    m = '0;
    for (int w = 0; w < MW / 32; w++) m[32*w +: 32] = $urandom();
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [MW-1:0] zero, exp;
    zero = '0;
    rst_n = 1'b0;
    q = rand_small(); k = rand_small(); v = rand_full();
    repeat (3) step();
    checks++;
    if (token_out !== zero) $display("FAIL reset_hold: got %h want %h", token_out, zero); else passed++;
    rst_n = 1'b1;
    exp = model(q, k, v);
    step();
    checks++;
    if (token_out !== zero) $display("FAIL reset_edge1: got %h want %h", token_out, zero); else passed++;
    step();
    checks++;
    if (token_out !== zero) $display("FAIL reset_edge2: got %h want %h", token_out, zero); else passed++;
    step();
    checks++;
    if (token_out !== exp) $display("FAIL reset_edge3: got %h want %h", token_out, exp); else passed++;
  endtask

  task automatic test_uniform();
    logic [MW-1:0] vv, exp;
    vv = '0;
    for (int i = 0; i < TN; i++)
      for (int d = 0; d < TD; d++) vv = set_el(vv, i, d, 256 * (d + 1));
    exp = vv;
    q = '0; k = '0; v = vv;
    repeat (3) step();
    checks++;
    if (token_out !== exp) $display("FAIL uniform: got %h want %h", token_out, exp); else passed++;
  endtask

  task automatic test_one_hot();
    logic [MW-1:0] qq, kk, vv, exp;
    qq = '0; kk = '0;
    for (int i = 0; i < TN; i++) qq = set_el(qq, i, 0, 16'h0800);
    kk = set_el(kk, 0, 0, 16'h0800);
    vv = rand_full();
    exp = '0;
    for (int i = 0; i < TN; i++)
      for (int d = 0; d < TD; d++) exp = set_el(exp, i, d, get_el(vv, 0, d));
    q = qq; k = kk; v = vv;
    repeat (3) step();
    checks++;
    if (token_out !== exp) $display("FAIL one_hot: got %h want %h", token_out, exp); else passed++;
    exp = model(qq, kk, vv);
    checks++;
    if (token_out !== exp) $display("FAIL one_hot_model: got %h want %h", token_out, exp); else passed++;
  endtask

  task automatic test_saturation();
    logic [MW-1:0] vv, exp;
    int colsum;
    q = '0; k = '0;
    for (int i = 0; i < TN; i++)
      for (int d = 0; d < TD; d++) begin
        q = set_el(q, i, d, 16'h7FFF);
        k = set_el(k, i, d, 16'h7FFF);
      end
    vv = rand_full();
    v = vv;
    exp = '0;
    for (int d = 0; d < TD; d++) begin
      colsum = 0;
      for (int j = 0; j < TN; j++) colsum += get_el(vv, j, d);
      for (int i = 0; i < TN; i++) exp = set_el(exp, i, d, colsum >>> 3);
    end
    repeat (3) step();
    checks++;
    if (token_out !== exp) $display("FAIL saturation: got %h want %h", token_out, exp); else passed++;
  endtask

  task automatic test_pipeline_order();
    logic [MW-1:0] bq [3], bk [3], bv [3];
    logic [MW-1:0] exp;
    for (int b = 0; b < 3; b++) begin
      bq[b] = rand_small(); bk[b] = rand_small(); bv[b] = rand_full();
    end
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        q = bq[c]; k = bk[c]; v = bv[c];
      end
      step();
      if (c >= 2) begin
        exp = model(bq[c-2], bk[c-2], bv[c-2]);
        checks++;
        if (token_out !== exp) $display("FAIL order_blk%0d: got %h want %h", c - 2, token_out, exp);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [MW-1:0] bq [3], bk [3], bv [3];
    logic [MW-1:0] exp, zero;
    zero = '0;
    for (int b = 0; b < 3; b++) begin
      bq[b] = rand_small(); bk[b] = rand_small(); bv[b] = rand_full();
      q = bq[b]; k = bk[b]; v = bv[b];
      step();
    end
    exp = model(bq[0], bk[0], bv[0]);
    checks++;
    if (token_out !== exp) $display("FAIL async_pre: got %h want %h", token_out, exp); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (token_out !== zero) $display("FAIL async_clear: got %h want %h", token_out, zero); else passed++;
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (token_out !== zero) $display("FAIL async_edge1: got %h want %h", token_out, zero); else passed++;
    step();
    checks++;
    if (token_out !== zero) $display("FAIL async_edge2: got %h want %h", token_out, zero); else passed++;
    step();
    exp = model(bq[2], bk[2], bv[2]);
    checks++;
    if (token_out !== exp) $display("FAIL async_edge3: got %h want %h", token_out, exp); else passed++;
  endtask

  task automatic test_back_to_back(input int nblk);
    logic [MW-1:0] expq [$];
    logic [MW-1:0] exp;
    for (int c = 0; c < nblk + 2; c++) begin
      if (c < nblk) begin
        q = rand_small(); k = rand_small(); v = rand_full();
        expq.push_back(model(q, k, v));
      end
      step();
      if (c >= 2) begin
        exp = expq.pop_front();
        checks++;
        if (token_out !== exp) $display("FAIL b2b_blk%0d: got %h want %h", c - 2, token_out, exp);
        else passed++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    q = '0; k = '0; v = '0;
    test_reset();
    test_uniform();
    test_one_hot();
    test_saturation();
    test_pipeline_order();
    test_async_reset();
    test_back_to_back(20);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/attention_top.md
# attention_top

Pipelined fixed-point scaled-dot-product attention core, computing `softmax(Q·Kᵀ)·V` for one block of `TOKEN_NUM` tokens per clock. It sits in the accelerator datapath after the Q/K/V projection units and feeds the output projection. It is a three-stage pipeline:

- **Stage 1:** score matrix A.
- **Stage 2:** row softmax S.
- **Stage 3:** weighted sum of V.

## Interface
- `DATA_WIDTH`, default 16: element width. Fixed Q8.8 two's complement; only 16 is supported.
- `TOKEN_DIM`, default 4: elements per token.
- `TOKEN_NUM`, default 8: tokens per block.
- `SCALE_SHIFT`, default 1: arithmetic right shift applied to scores when scaling is enabled (≈1/√TOKEN_DIM).
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `Q`  input  DATA_WIDTH·TOKEN_DIM·TOKEN_NUM: query matrix.
- `K`  input  same width: key matrix.
- `V`  input  same width: value matrix.
- `token_out`  output  same width: attention output matrix.
- Packing for all matrix ports: element (token i, dim j) occupies bits `[DATA_WIDTH·(i·TOKEN_DIM+j+1)−1 : DATA_WIDTH·(i·TOKEN_DIM+j)]`.

## Operation
- **Stage 1 (register `A_stage_1_to_2`, TOKEN_NUM×TOKEN_NUM, same packing with row length TOKEN_NUM):**
  - A[i][j] = Σ_d Q[i][d]·K[j][d].
  - Signed 32-bit products, full-width accumulate.
  - Result is shifted right arithmetically by 8, optionally scaled (see Configuration), then saturated to 16-bit signed.
  - V is registered alongside A.
- **Stage 2 (register `S_stage_2_to_3`, unsigned Q8.8):** for each row i:
  - m = max_j A[i][j]; x_j = A[i][j] − m (17-bit, ≤ 0).
  - Base-2 conversion: y = (−x)·1.4375, implemented as −x + (−x>>1) − (−x>>4). Let n = y[..:8] and f = y[7:0].
  - e_j = (256 − (f>>1)) >> n; e_j = 0 when n ≥ 16.
  - sum = Σ e_j (≥ 256).
  - S[i][j] = (e_j<<8)/sum, unsigned truncating divide, range 0..256.
  - V is registered again.
- **Stage 3 (register `token_out`):**
  - out[i][d] = (Σ_j S[i][j]·V[j][d]) >>> 8, where S is zero-extended and V is signed.
  - Result saturated to 16-bit signed.
- All stage logic is combinational between registers. There are no handshakes: a new block is accepted every cycle.

## Timing
- Latency: `token_out` after rising edge N+3 reflects the Q/K/V presented before rising edge N+1.
- Throughput: one block per cycle. Blocks leave in input order with no interleaving of rows between blocks.
- Reset:
  - While `rst_n` is low, all pipeline registers (A, S, both V copies, `token_out`) are 0.
  - Assertion between edges clears `token_out` immediately and flushes in-flight blocks.
- After reset release, `token_out` stays 0 until the 3rd rising edge. Partially filled stages propagate zeros: a zero A row yields a uniform S row, and with zero V this still gives output 0.
- Boundary conditions:
  - An all-equal score row gives uniform S = 256/TOKEN_NUM.
  - Score saturation happens before the max subtraction.

## Configuration
- `ATTN_SCALE_EN`:
  - Defined: stage-1 scores are arithmetically shifted right by `SCALE_SHIFT` before saturation.
  - Undefined: scores are unscaled.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst_n`=0 with nonzero Q/K/V → `token_out`=0. Release, then apply 2 edges → still 0. The 3rd edge gives the first valid result.
- **Uniform softmax:** Q=K=0, V[i][d]=0x0100·(d+1) → every S = 0x0020; every output row = [0x0100, 0x0200, 0x0300, 0x0400].
- **One-hot dominance (`ATTN_SCALE_EN` defined):**
  - Stimulus: Q[i]=[0x0800,0,0,0] for all i; K[0]=[0x0800,0,0,0], other K=0; V arbitrary.
  - Response: A[i][0]=0x2000 and all other A=0; S row = [0x0100, 0, …, 0]; every output row = V row 0 exactly.
- **Pipeline ordering:** three distinct blocks applied on consecutive cycles → results appear in the same order on edges 3, 4, 5, each matching its own golden model.
- **Asynchronous reset mid-stream:** pulse `rst_n` low between edges while blocks are in flight → `token_out` goes to 0 without a clock edge. The next 2 edges output 0.
- **Saturation:** Q=K all 0x7FFF → A saturates to 0x7FFF; softmax is uniform; the output equals the column means of V.
